row_bank_demux: RTL and testbench
=================================

Name: row_bank_demux

Overview:
- Write-side counterpart of the bank-select read mux in data_router.
- Accepts a valid/ready stream of BUFW-wide rows and scatters them round-robin across POY on-chip banks: row n goes to bank n mod POY at address n div POY.
- Produces per-bank write enables, a shared address and registered data, so the read-side bank mux can later fetch the rows in the same bank order.

Parameters:
- DW, 8, bits per data element.
- POY, 3, number of banks (1..4; bank index is a fixed 2 bits).
- BUFW, 32, elements per row.
- DEPTH, 64, rows per bank.
- AW, $clog2(DEPTH), bank address width.
- CW, $clog2(POY*DEPTH+1), row-count width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a transfer (ignored unless idle)
- cfg_total  input  CW  rows to accept; sampled on start
- in_valid  input  1  input row valid
- in_ready  output  1  block can accept a row
- in_data  input  [DW-1:0] x BUFW (unpacked)  input row
- wr_en  output  POY  one-hot bank write enable
- wr_bank  output  2  index of the bank being written
- wr_addr  output  AW  write address
- wr_data  output  [DW-1:0] x BUFW  registered row
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, wr_data all 0, state IDLE, counters 0.
- Reset asserted mid-transfer aborts immediately; no partial-state recovery.
- FSM states and transitions:
  - IDLE -> WRITE on start when latched count > 0.
  - IDLE -> DONE on start when cfg_total == 0.
  - WRITE -> DONE on the cycle the last row is accepted.
  - DONE -> IDLE after exactly one cycle.
- start while busy=1 is ignored.
- cfg_total > POY*DEPTH is clamped to POY*DEPTH when latched.
- in_ready:
  - High in WRITE only (combinational from state, plus the optional stall).
  - Drops the cycle after the final accept.
- A beat is accepted when in_valid && in_ready.
- Accept in cycle k produces, in cycle k+1:
  - wr_en[bank_ptr] = 1;
  - wr_bank = bank_ptr;
  - wr_addr = addr_ptr;
  - wr_data = the accepted row.
  This is a one-cycle latency; wr_en is 0 in every cycle that follows no accept.
- Pointers: bank_ptr starts at 0 and increments per accept. At POY-1 it wraps to 0 and addr_ptr increments. Both pointers reset to 0 on every start.
- done:
  - High in the cycle the FSM is in DONE, which coincides with the final wr_en.
  - For a zero count, done is high in cycle start+1 with no writes.
- wr_bank and wr_addr hold their last value while wr_en = 0.
- Gaps in in_valid stall the pointers; no rows are lost or duplicated.
- A back-to-back start in the DONE cycle is ignored; start is accepted in IDLE only.

Optional Feature:
- Macro: DEMUX_BANK_STALL_EN.
- With the macro defined:
  - Adds input port bank_stall [POY].
  - in_ready = (state==WRITE) && !bank_stall[bank_ptr], so a busy target bank back-pressures the stream.
  - Pointers hold while stalled.
- Without the macro: the port is absent and in_ready = (state==WRITE).

Decomposition:
- Shared package data_router_pkg holds:
  - state enum (IDLE, WRITE, DONE);
  - bank_idx_t (2-bit);
  - the MAX_BANKS=4 constant, used in an elaboration check POY<=MAX_BANKS.
- One sub-module, bank_ptr_gen: bank/address round-robin counter with clear and advance inputs. Everything else lives in the top.

Test Plan:
- POY=3, DEPTH=64, start with cfg_total=7, in_valid held 1:
  - wr_en bank sequence 0,1,2,0,1,2,0 with wr_addr 0,0,0,1,1,1,2, each one cycle after its accept;
  - done pulses with the 7th write; in_ready low the cycle after.
- Same transfer with in_valid low on cycles 2 and 5 of the stream: no wr_en in the following cycles, pointers unchanged, same final bank/addr order.
- start with cfg_total=0: done=1 and busy=1 at start+1, no wr_en ever, IDLE at start+2.
- cfg_total=200: exactly 192 writes; last write is bank 2, addr 63, concurrent with done.
- rst_n pulsed low after 4 accepts: all outputs 0 immediately. A new start then writes bank 0 addr 0 first.
- DEMUX_BANK_STALL_EN defined, bank_stall[1]=1 while bank_ptr=1: in_ready=0 and no accept until the stall releases, then the row lands in bank 1 at the correct addr.

Source files
------------

// File: rtl/row_bank_demux_pkg.sv
// Shared types for the data_router bank mux/demux pair: FSM states, bank index, bank-count limit.
package data_router_pkg;

  localparam int MAX_BANKS = 4;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/row_bank_demux_if.sv
// Row stream in, per-bank write port out. Adds bank_stall when DEMUX_BANK_STALL_EN is defined.
interface row_bank_demux_if
  import data_router_pkg::*;
#(
  parameter int DW    = 8,
  parameter int POY   = 3,
  parameter int BUFW  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(POY*DEPTH+1)
) ();

  logic            start;
  logic [CW-1:0]   cfg_total;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data [BUFW];
  logic [POY-1:0]  wr_en;
  bank_idx_t       wr_bank;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data [BUFW];
  logic            busy;
  logic            done;

`ifdef DEMUX_BANK_STALL_EN
  logic [POY-1:0]  bank_stall;

  modport master (
    output start, cfg_total, in_valid, in_data, bank_stall,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, cfg_total, in_valid, in_data, bank_stall,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
  );
`else
  modport master (
    output start, cfg_total, in_valid, in_data,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, cfg_total, in_valid, in_data,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done
  );
`endif

endinterface

// File: rtl/row_bank_demux_ptr_gen.sv
// Round-robin bank/address counter: bank steps per advance, address steps on bank wrap.
// Clear has priority over advance; one-cycle register latency.
module bank_ptr_gen
  import data_router_pkg::*;
#(
  parameter int POY = 3,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output bank_idx_t     o_bank,
  output logic [AW-1:0] o_addr
);

  localparam bank_idx_t LAST_BANK = bank_idx_t'(POY - 1);

  bank_idx_t     r_bank;
  logic [AW-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_bank <= '0;
      r_addr <= '0;
    end else if (i_adv) begin
      if (r_bank == LAST_BANK) begin
        r_bank <= '0;
        r_addr <= r_addr + AW'(1);
      end else begin
        r_bank <= r_bank + 2'd1;
      end
    end
  end

  assign o_bank = r_bank;
  assign o_addr = r_addr;

endmodule

// File: rtl/row_bank_demux.sv
// Scatters a valid/ready row stream round-robin over POY banks; write port is one cycle after accept.
// Backpressure: in_ready only in WRITE (and, with DEMUX_BANK_STALL_EN, not while the target bank stalls).
module row_bank_demux
  import data_router_pkg::*;
#(
  parameter int DW    = 8,
  parameter int POY   = 3,
  parameter int BUFW  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(POY*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  row_bank_demux_if.slave   bus
);

  localparam logic [CW-1:0] MAX_ROWS = CW'(POY * DEPTH);

  if (POY < 1 || POY > MAX_BANKS) begin : g_poy_check
    $error("row_bank_demux: POY must be in 1..MAX_BANKS");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_total;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_total_clamped;
  logic            w_start_ok;
  logic            w_ready;
  logic            w_accept;
  logic            w_last;
  logic            w_stall;
  bank_idx_t       w_bank;
  logic [AW-1:0]   w_addr;
  logic [POY-1:0]  w_bank_oh;

  logic [POY-1:0]  r_wr_en;
  bank_idx_t       r_wr_bank;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data [BUFW];

  bank_ptr_gen #(.POY(POY), .AW(AW)) u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok),
    .i_adv  (w_accept),
    .o_bank (w_bank),
    .o_addr (w_addr)
  );

  always_comb begin
    w_bank_oh = '0;
    for (int i = 0; i < POY; i++) begin
      w_bank_oh[i] = (w_bank == bank_idx_t'(i));
    end
  end

`ifdef DEMUX_BANK_STALL_EN
  assign w_stall = |(bus.bank_stall & w_bank_oh);
`else
  assign w_stall = 1'b0;
`endif

  assign w_total_clamped = (bus.cfg_total > MAX_ROWS) ? MAX_ROWS : bus.cfg_total;
  assign w_start_ok      = bus.start && (r_state == ST_IDLE);
  assign w_ready         = (r_state == ST_WRITE) && !w_stall;
  assign w_accept        = bus.in_valid && w_ready;
  // r_total is never zero in WRITE, so the subtraction cannot wrap there.
  assign w_last          = w_accept && (r_count == r_total - CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = (bus.cfg_total == '0) ? ST_DONE : ST_WRITE;
      ST_WRITE: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:                 w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_total <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_total <= w_total_clamped;
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= '0;
      r_wr_bank <= '0;
      r_wr_addr <= '0;
      for (int i = 0; i < BUFW; i++) begin
        r_wr_data[i] <= '0;
      end
    end else begin
      r_wr_en <= w_accept ? w_bank_oh : '0;
      if (w_accept) begin
        r_wr_bank <= w_bank;
        r_wr_addr <= w_addr;
        r_wr_data <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_bank  = r_wr_bank;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_row_bank_demux.sv
// Directed and randomized sequences checked against a row-number model: row n -> bank n%POY, addr n/POY.
module tb_row_bank_demux;

  localparam int DW    = 8;
  localparam int POY   = 3;
  localparam int BUFW  = 32;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(POY*DEPTH+1);
  localparam int NROWS = POY * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  row_bank_demux_if #(.DW(DW), .POY(POY), .BUFW(BUFW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) bus ();

  row_bank_demux #(.DW(DW), .POY(POY), .BUFW(BUFW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_writes = 0;

  // Model: phase 0 idle, 1 accepting rows, 2 completion cycle; m_n rows accepted so far.
  int             m_phase = 0;
  int             m_total = 0;
  int             m_n     = 0;
  logic [POY-1:0] e_wr_en;
  int             e_bank;
  int             e_addr;
  logic [DW-1:0]  e_data [BUFW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    bit same;
    same = 1'b1;
    chk("wr_en",   64'(bus.wr_en),   64'(e_wr_en));
    chk("wr_bank", 64'(bus.wr_bank), 64'(e_bank));
    chk("wr_addr", 64'(bus.wr_addr), 64'(e_addr));
    chk("done",    64'(bus.done),    64'(m_phase == 2));
    chk("busy",    64'(bus.busy),    64'(m_phase != 0));
    for (int i = 0; i < BUFW; i++) begin
      if (bus.wr_data[i] !== e_data[i]) same = 1'b0;
    end
    chk("wr_data", 64'(same), 64'(1));
  endtask

  // One clock: drive inputs, check in_ready, clock, advance model, check outputs.
  task automatic tick(input bit v, input bit st, input int tot);
    logic [DW-1:0] row [BUFW];
    bit stl;
    bit acc;
    for (int i = 0; i < BUFW; i++) row[i] = DW'($urandom);
    bus.start     = st;
    bus.cfg_total = CW'(tot);
    bus.in_valid  = v;
    bus.in_data   = row;
    stl = 1'b0;
`ifdef DEMUX_BANK_STALL_EN
    stl = bus.bank_stall[m_n % POY];
`endif
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(m_phase == 1 && !stl));
    acc = v && (m_phase == 1) && !stl;
    @(posedge clk);
    #1;
    e_wr_en = '0;
    case (m_phase)
      0: if (st) begin
        m_total = (tot > NROWS) ? NROWS : tot;
        m_n     = 0;
        m_phase = (m_total == 0) ? 2 : 1;
      end
      1: if (acc) begin
        e_wr_en[m_n % POY] = 1'b1;
        e_bank = m_n % POY;
        e_addr = m_n / POY;
        e_data = row;
        m_n++;
        if (m_n == m_total) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    if (bus.wr_en != '0) n_writes++;
    chk_outputs();
  endtask

  task automatic run_until_idle(input int pct_valid, input int bound);
    int k;
    k = 0;
    while (m_phase != 0 && k < bound) begin
      tick($urandom_range(0, 99) < pct_valid, 1'b0, 0);
      k++;
    end
    chk("drain_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic do_reset();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    m_phase = 0;
    m_n     = 0;
    e_wr_en = '0;
    e_bank  = 0;
    e_addr  = 0;
    for (int i = 0; i < BUFW; i++) e_data[i] = '0;
    chk_outputs();
    chk("in_ready_rst", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.cfg_total = '0;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < BUFW; i++) bus.in_data[i] = '0;
`ifdef DEMUX_BANK_STALL_EN
    bus.bank_stall = '0;
`endif
    do_reset();

    // Seven rows, valid held high.
    tick(1'b0, 1'b1, 7);
    repeat (7) tick(1'b1, 1'b0, 0);
    repeat (3) tick(1'b0, 1'b0, 0);

    // Same transfer with valid gaps on stream cycles 2 and 5.
    tick(1'b0, 1'b1, 7);
    for (int c = 0; c < 9; c++) tick(!(c == 2 || c == 5), 1'b0, 0);
    repeat (2) tick(1'b0, 1'b0, 0);

    // Zero-length transfer.
    tick(1'b0, 1'b1, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);

    // start while busy and in the DONE cycle is ignored.
    tick(1'b0, 1'b1, 4);
    tick(1'b1, 1'b1, 9);
    tick(1'b1, 1'b1, 9);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b1, 9);
    repeat (2) tick(1'b0, 1'b0, 0);

    // Oversized count clamps to POY*DEPTH.
    n_writes = 0;
    tick(1'b0, 1'b1, 200);
    run_until_idle(100, 300);
    chk("clamp_writes", 64'(n_writes), 64'(192));
    chk("last_bank",    64'(bus.wr_bank), 64'(2));
    chk("last_addr",    64'(bus.wr_addr), 64'(63));

    // Random counts and valid patterns.
    repeat (4) begin
      tick(1'b0, 1'b1, int'($urandom_range(1, 25)));
      run_until_idle(60, 200);
      tick(1'b0, 1'b0, 0);
    end

    // Reset after four accepts, then a fresh transfer restarts at bank 0 addr 0.
    tick(1'b0, 1'b1, 10);
    repeat (4) tick(1'b1, 1'b0, 0);
    do_reset();
    tick(1'b0, 1'b1, 3);
    run_until_idle(100, 20);

`ifdef DEMUX_BANK_STALL_EN
    // Bank 1 stalls while it is the target; the row lands there once released.
    tick(1'b0, 1'b1, 6);
    for (int c = 0; c < 40 && m_phase != 0; c++) begin
      bus.bank_stall = (c < 6 && (m_n % POY) == 1) ? POY'(2) : '0;
      tick(1'b1, 1'b0, 0);
    end
    bus.bank_stall = '0;
    chk("stall_drain", 64'(bus.busy), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
